capture_bank_controller: RTL and testbench

CAPTURE_BANK_CONTROLLER -- requirements
Module: capture_bank_controller

---
 rtl/capture_bank_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_capture_bank_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_bank_controller.sv
// capture_bank_controller
//
// Purpose:
//   Write-side controller for a multi-bank capture memory. While
//   signal_detected is high, consecutive samples are written into the current
//   bank. A bank closes either because it is full or because the signal
//   dropped. A closed bank is flagged in bank_valid until the consumer
//   releases it. When the bank the writer needs is still unread, the capture
//   is refused (or truncated) and the controller waits in DROP until the
//   signal goes away.
//
// Parameters:
//   DEPTH     samples per bank (2..4096)
//   BANK_BITS log2 of the bank count, NB = 2**BANK_BITS (1..3)
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous, active-high reset
//   signal_detected        capture request (level)
//   bank_release           consumer frees bank release_idx this cycle
//   release_idx            bank being released
//   addr_in                write address {wr_bank, idx}
//   we                     memory write enable (combinational)
//   bank_valid             per-bank "holds unread capture" flags
//   done_valid             one-cycle pulse: a bank closed
//   done_bank / done_len   bank that closed and how many samples it holds;
//                          held stable between done_valid pulses
//   memorization_completed one-cycle pulse when a capture ends normally
//   overflow               one-cycle pulse: capture refused or truncated
//   state_reg              current FSM state (IDLE=0 CAPTURE=1 DONE=2 DROP=3)
//   drop_count             (only with CAPTURE_DROP_COUNT_EN) saturating count
//                          of overflow pulses
//
// Configuration macro:
//   CAPTURE_DROP_COUNT_EN  adds the drop_count output and its counter.
//
// All pulses are registered, so they appear the cycle after the decision
// that caused them; memorization_completed therefore follows done_valid by
// one cycle.

module capture_bank_controller #(
  parameter int DEPTH     = 200,
  parameter int BANK_BITS = 1,
  localparam int NB = 2 ** BANK_BITS,
  localparam int IW = $clog2(DEPTH),
  localparam int AW = BANK_BITS + IW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 signal_detected,
  input  logic                 bank_release,
  input  logic [BANK_BITS-1:0] release_idx,
  output logic [AW-1:0]        addr_in,
  output logic                 we,
  output logic [NB-1:0]        bank_valid,
  output logic                 done_valid,
  output logic [BANK_BITS-1:0] done_bank,
  output logic [IW:0]          done_len,
  output logic                 memorization_completed,
  output logic                 overflow,
  output logic [1:0]           state_reg
`ifdef CAPTURE_DROP_COUNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BANK_BITS-1:0] wr_bank_q, wr_bank_d;
  logic [NB-1:0]        bank_valid_q, bank_valid_d;
  logic [BANK_BITS-1:0] done_bank_q, done_bank_d;
  logic [IW:0]          done_len_q, done_len_d;
  logic                 done_valid_q, done_valid_d;
  logic                 memo_q, memo_d;
  logic                 overflow_q, overflow_d;

  logic                 close_en;
  logic [IW:0]          close_len;
  logic [BANK_BITS-1:0] next_bank;

  // Banks are used round-robin; the natural wrap of BANK_BITS gives modulo NB.
  assign next_bank = wr_bank_q + BANK_BITS'(1);

  // State register and all other flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_bank_q    <= '0;
      bank_valid_q <= '0;
      done_bank_q  <= '0;
      done_len_q   <= '0;
      done_valid_q <= 1'b0;
      memo_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_bank_q    <= wr_bank_d;
      bank_valid_q <= bank_valid_d;
      done_bank_q  <= done_bank_d;
      done_len_q   <= done_len_d;
      done_valid_q <= done_valid_d;
      memo_q       <= memo_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic. Bank availability is judged on the flags as they stand
  // this cycle, so a release arriving in the same cycle only helps from the
  // next cycle on.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_bank_d  = wr_bank_q;
    close_en   = 1'b0;
    close_len  = '0;
    overflow_d = 1'b0;
    memo_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (signal_detected) begin
          if (!bank_valid_q[wr_bank_q]) begin
            state_d = CAPTURE;
            idx_d   = '0;
          end else begin
            state_d    = DROP;
            overflow_d = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (signal_detected) begin
          if (idx_q == IW'(DEPTH - 1)) begin
            // Bank full: close it and roll straight into the next bank.
            close_en  = 1'b1;
            close_len = (IW + 1)'(DEPTH);
            wr_bank_d = next_bank;
            idx_d     = '0;
            if (bank_valid_q[next_bank]) begin
              state_d    = DROP;
              overflow_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (idx_q != '0) begin
          close_en  = 1'b1;
          close_len = {1'b0, idx_q};
          wr_bank_d = next_bank;
          idx_d     = '0;
          state_d   = DONE;
        end else begin
          // Nothing was written into this bank; reuse it next time.
          state_d = IDLE;
        end
      end

      DONE: begin
        memo_d  = 1'b1;
        state_d = IDLE;
      end

      DROP: begin
        if (!signal_detected) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Release first, then set, so a bank closing this cycle stays flagged.
    bank_valid_d = bank_valid_q;
    if (bank_release) begin
      bank_valid_d[release_idx] = 1'b0;
    end
    if (close_en) begin
      bank_valid_d[wr_bank_q] = 1'b1;
    end

    done_valid_d = close_en;
    done_bank_d  = close_en ? wr_bank_q : done_bank_q;
    done_len_d   = close_en ? close_len : done_len_q;
  end

  // Outputs.
  always_comb begin
    we      = (state_q == CAPTURE) && signal_detected;
    addr_in = {wr_bank_q, idx_q};
  end

  assign bank_valid             = bank_valid_q;
  assign done_valid             = done_valid_q;
  assign done_bank              = done_bank_q;
  assign done_len               = done_len_q;
  assign memorization_completed = memo_q;
  assign overflow               = overflow_q;
  assign state_reg              = state_q;

`ifdef CAPTURE_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  // Counts the same events that raise overflow, sticking at all-ones.
  always_comb begin
    drop_count_d = drop_count_q;
    if (overflow_d && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_capture_bank_controller.sv
// Testbench for capture_bank_controller (DEPTH=200, BANK_BITS=1).
//
// A behavioural model tracks, in plain counters, how many samples sit in the
// bank being filled, which banks hold unread captures and which pulses are
// due; a compare process checks every DUT output against it on each falling
// edge. Directed scenarios pin the model with hand-computed literals, then a
// randomized burst/release phase runs against the model.

module tb_capture_bank_controller;

  localparam int DEPTH     = 200;
  localparam int BANK_BITS = 1;
  localparam int NB        = 2 ** BANK_BITS;
  localparam int IW        = $clog2(DEPTH);
  localparam int AW        = BANK_BITS + IW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 signal_detected = 1'b0;
  logic                 bank_release = 1'b0;
  logic [BANK_BITS-1:0] release_idx = '0;
  logic [AW-1:0]        addr_in;
  logic                 we;
  logic [NB-1:0]        bank_valid;
  logic                 done_valid;
  logic [BANK_BITS-1:0] done_bank;
  logic [IW:0]          done_len;
  logic                 memorization_completed;
  logic                 overflow;
  logic [1:0]           state_reg;
`ifdef CAPTURE_DROP_COUNT_EN
  logic [15:0]          drop_count;
`endif

  capture_bank_controller #(
    .DEPTH     (DEPTH),
    .BANK_BITS (BANK_BITS)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .signal_detected        (signal_detected),
    .bank_release           (bank_release),
    .release_idx            (release_idx),
    .addr_in                (addr_in),
    .we                     (we),
    .bank_valid             (bank_valid),
    .done_valid             (done_valid),
    .done_bank              (done_bank),
    .done_len               (done_len),
    .memorization_completed (memorization_completed),
    .overflow               (overflow),
    .state_reg              (state_reg)
`ifdef CAPTURE_DROP_COUNT_EN
    ,
    .drop_count             (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, return at the
  // following falling edge where outputs are stable.
  task automatic applyStimulus(input bit s, input bit r, input int ri);
    @(posedge clk);
    #1;
    signal_detected = s;
    bank_release    = r;
    release_idx     = ri[BANK_BITS-1:0];
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    reset = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 waiting, 1 capturing, 2 finishing, 3 refusing (matches the
  // documented state_reg values).
  int m_mode, m_bank, m_count, m_done_bank, m_done_len, m_drops, m_closed;
  bit m_valid [NB];
  bit m_free_before [NB];
  bit m_done_pulse, m_memo, m_ovf;
  logic [NB-1:0] exp_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_bank = 0; m_count = 0; m_done_bank = 0; m_done_len = 0;
      m_drops = 0; m_done_pulse = 0; m_memo = 0; m_ovf = 0;
      for (int i = 0; i < NB; i++) m_valid[i] = 0;
    end else begin
      for (int i = 0; i < NB; i++) m_free_before[i] = !m_valid[i];
      m_done_pulse = 0; m_memo = 0; m_ovf = 0; m_closed = -1;
      case (m_mode)
        0: if (signal_detected) begin
             if (m_free_before[m_bank]) begin m_mode = 1; m_count = 0; end
             else begin m_mode = 3; m_ovf = 1; end
           end
        1: if (signal_detected) begin
             m_count++;
             if (m_count == DEPTH) begin
               m_closed = m_bank; m_done_len = DEPTH;
               m_bank = (m_bank + 1) % NB; m_count = 0;
               if (!m_free_before[m_bank]) begin m_mode = 3; m_ovf = 1; end
             end
           end else if (m_count > 0) begin
             m_closed = m_bank; m_done_len = m_count;
             m_bank = (m_bank + 1) % NB; m_count = 0; m_mode = 2;
           end else begin
             m_mode = 0;
           end
        2: begin m_memo = 1; m_mode = 0; end
        default: if (!signal_detected) m_mode = 0;
      endcase
      if (bank_release) m_valid[release_idx] = 0;
      if (m_closed >= 0) begin
        m_valid[m_closed] = 1; m_done_bank = m_closed; m_done_pulse = 1;
      end
      if (m_ovf && m_drops < 65535) m_drops++;
    end
  end

  // Compare process: every falling edge, every output.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) exp_valid[i] = m_valid[i];
    checkOutput("state_reg", state_reg, m_mode);
    checkOutput("we", we, (m_mode == 1) && signal_detected);
    checkOutput("addr_in", addr_in, m_bank * (1 << IW) + m_count);
    checkOutput("bank_valid", bank_valid, exp_valid);
    checkOutput("done_valid", done_valid, m_done_pulse);
    checkOutput("done_bank", done_bank, m_done_bank);
    checkOutput("done_len", done_len, m_done_len);
    checkOutput("memorization_completed", memorization_completed, m_memo);
    checkOutput("overflow", overflow, m_ovf);
`ifdef CAPTURE_DROP_COUNT_EN
    checkOutput("drop_count", drop_count, m_drops);
`endif
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int we_count, ovf_count, done_count;
    int first_addr;
    int burst, gap, cycles;
`ifdef CAPTURE_DROP_COUNT_EN
    int drops_before;
`endif

    $display("[TB] start");
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    reset = 1'b0;
    checkOutput("reset_state", state_reg, 0);
    checkOutput("reset_bank_valid", bank_valid, 0);
    checkOutput("reset_done_len", done_len, 0);

    // Single short capture: 50 writes into bank 0.
    we_count = 0;
    for (int i = 1; i <= 51; i++) begin
      applyStimulus(1, 0, 0);
      if (we) begin
        checkOutput("short_addr", addr_in, we_count);
        we_count++;
      end
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("short_done_valid", done_valid, 1);
    checkOutput("short_done_len", done_len, 50);
    checkOutput("short_done_bank", done_bank, 0);
    checkOutput("short_bank_valid", bank_valid, 2'b01);
    checkOutput("short_memo_early", memorization_completed, 0);
    applyStimulus(0, 0, 0);
    checkOutput("short_memo", memorization_completed, 1);
    checkOutput("short_we_cycles", we_count, 50);

    // Long capture with no releases: both banks fill, then overflow.
    pulseReset();
    we_count = 0; ovf_count = 0; done_count = 0;
    for (int i = 1; i <= 451; i++) begin
      applyStimulus(1, 0, 0);
      we_count   += int'(we);
      ovf_count  += int'(overflow);
      done_count += int'(done_valid);
    end
    checkOutput("long_we_cycles", we_count, 400);
    checkOutput("long_overflows", ovf_count, 1);
    checkOutput("long_dones", done_count, 2);
    checkOutput("long_state_drop", state_reg, 3);
    checkOutput("long_bank_valid", bank_valid, 2'b11);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("long_back_idle", state_reg, 0);

    // Both banks full: refused, then release bank 0 and capture into it.
    we_count = 0; ovf_count = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i < 5, 0, 0);
      we_count  += int'(we);
      ovf_count += int'(overflow);
    end
    checkOutput("refused_we", we_count, 0);
    checkOutput("refused_overflow", ovf_count, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("release_bank_valid", bank_valid, 2'b10);
    first_addr = -1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, 0, 0);
      if (we && first_addr < 0) first_addr = int'(addr_in);
    end
    checkOutput("reuse_first_addr", first_addr, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reuse_done_len", done_len, 10);
    checkOutput("reuse_done_bank", done_bank, 0);
    checkOutput("reuse_bank_valid", bank_valid, 2'b11);

`ifdef CAPTURE_DROP_COUNT_EN
    drops_before = int'(drop_count);
    for (int k = 0; k < 3; k++) begin
      repeat (3) applyStimulus(1, 0, 0);
      repeat (2) applyStimulus(0, 0, 0);
    end
    checkOutput("drop_count_plus3", drop_count, drops_before + 3);
`endif

    // Release of bank 0 in the same cycle bank 1 fills.
    pulseReset();
    for (int i = 1; i <= 401; i++) begin
      applyStimulus(1, i == 401, 0);
      if (i == 401) checkOutput("coincident_addr", addr_in, 256 + 199);
    end
    applyStimulus(1, 0, 0);
    checkOutput("coincident_bank_valid", bank_valid, 2'b10);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Reset in the middle of a capture discards the partial bank.
    pulseReset();
    for (int i = 1; i <= 122; i++) applyStimulus(1, 0, 0);
    checkOutput("midreset_addr_before", addr_in, 120);
    reset = 1'b1;
    #1;
    checkOutput("midreset_bank_valid", bank_valid, 0);
    checkOutput("midreset_addr", addr_in, 0);
    checkOutput("midreset_we", we, 0);
    checkOutput("midreset_state", state_reg, 0);
    applyStimulus(0, 0, 0);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0);
      done_count += int'(done_valid);
    end
    checkOutput("midreset_no_done", done_count, 0);
    checkOutput("midreset_valid_after", bank_valid, 0);

    // Randomized bursts with random releases.
    pulseReset();
    cycles = 0;
    while (cycles < 8000) begin
      burst = $urandom_range(1, 450);
      gap   = $urandom_range(1, 30);
      for (int i = 0; i < burst + gap; i++) begin
        applyStimulus(i < burst, $urandom_range(0, 79) == 0,
                      int'($urandom_range(0, NB - 1)));
        cycles++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
